// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory stage and its SRAM timing.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam int DEF_ADDR_BASE   = 1024;
   localparam int DEF_WAIT_CYCLES = 2;

   localparam int SRAM_DW = 16;
   localparam int SRAM_AW = 18;
   localparam int WORD_AW = SRAM_AW - 1;

   // Access captured in IDLE; the rest of the transfer runs from this copy.
   typedef struct packed {
      logic               wr;
      logic [WORD_AW-1:0] word;
      logic [31:0]        data;
   } req_t;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase wait-state counter; flags the final cycle of a half-word phase.
module sram_phase_timer #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic last
);

   logic [3:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else          cnt <= cnt + 4'd1;
   end

   assign last = (cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_sram_stage.sv
// MIPS memory stage: 32-bit load/store as two half-word accesses to a 16-bit
// asynchronous SRAM, freezing the pipeline through ready while busy.
module mem_sram_stage
   import mem_pkg::*;
#(
   parameter int ADDR_BASE   = DEF_ADDR_BASE,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        ALU_result,
   input  logic [31:0]        ST_val,
   output logic [31:0]        rdata,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

   state_t             state;
   req_t               lat;
   logic               req;
   logic               phase;
   logic               last;
   logic               clr;
   logic               drive_en;
   logic [WORD_AW-1:0] word_in;

   assign req     = MEM_R_EN | MEM_W_EN;
   assign word_in = WORD_AW'((ALU_result - 32'(ADDR_BASE)) >> 2);
   assign phase   = (state == LO) | (state == HI);
   // Counter restarts outside the phases and at each phase boundary.
   assign clr     = ~phase | last;

   sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lat       <= '0;
         rdata     <= '0;
         SRAM_ADDR <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               lat       <= '{wr: MEM_W_EN, word: word_in, data: ST_val};
               SRAM_ADDR <= {word_in, 1'b0};
               state     <= LO;
            end
            LO: if (last) begin
               if (!lat.wr) rdata[15:0] <= SRAM_DQ;
               SRAM_ADDR <= {lat.word, 1'b1};
               state     <= HI;
            end
            HI: if (last) begin
               if (!lat.wr) rdata[31:16] <= SRAM_DQ;
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // WE_N rises on the last phase cycle so address and data are held past it.
   assign drive_en  = phase & lat.wr;
   assign SRAM_DQ   = drive_en ? ((state == HI) ? lat.data[31:16] : lat.data[15:0]) : 'z;
   assign SRAM_WE_N = ~(drive_en & ~last);
   assign SRAM_OE_N = ~(phase & ~lat.wr);
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   assign ready = ((state == IDLE) & ~req) | (state == DONE);

endmodule

// File: tb/tb_mem_sram_stage.sv
// Bench for mem_sram_stage: W=2 and W=4 instances share stimulus, each with an SRAM model.
module tb_mem_sram_stage;

   localparam int BASE = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        sel, r_en, w_en;
   logic [31:0] alu, st;

   logic [31:0] rdata2, rdata4;
   logic        rdy2, rdy4, we2, we4, oe2, oe4;
   logic        ce2, ub2, lb2, ce4, ub4, lb4;
   logic [17:0] a2, a4;
   wire  [15:0] dq2, dq4;

   logic [15:0] mem2 [0:262143];
   logic [15:0] mem4 [0:262143];

   mem_sram_stage #(.ADDR_BASE(BASE), .WAIT_CYCLES(2)) u2 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en & ~sel), .MEM_W_EN(w_en & ~sel),
      .ALU_result(alu), .ST_val(st), .rdata(rdata2), .ready(rdy2),
      .SRAM_DQ(dq2), .SRAM_ADDR(a2), .SRAM_WE_N(we2), .SRAM_OE_N(oe2),
      .SRAM_CE_N(ce2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2));

   mem_sram_stage #(.ADDR_BASE(BASE), .WAIT_CYCLES(4)) u4 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en & sel), .MEM_W_EN(w_en & sel),
      .ALU_result(alu), .ST_val(st), .rdata(rdata4), .ready(rdy4),
      .SRAM_DQ(dq4), .SRAM_ADDR(a4), .SRAM_WE_N(we4), .SRAM_OE_N(oe4),
      .SRAM_CE_N(ce4), .SRAM_UB_N(ub4), .SRAM_LB_N(lb4));

   // Asynchronous SRAM models: drive on OE_N low, capture while WE_N low.
   assign dq2 = oe2 ? 16'hzzzz : mem2[a2];
   assign dq4 = oe4 ? 16'hzzzz : mem4[a4];
   always @(posedge clk) if (!we2) mem2[a2] <= dq2;
   always @(posedge clk) if (!we4) mem4[a4] <= dq4;

   wire        rdy    = sel ? rdy4   : rdy2;
   wire [31:0] rdata  = sel ? rdata4 : rdata2;
   wire [17:0] sram_a = sel ? a4     : a2;
   wire        we     = sel ? we4    : we2;
   wire        oe     = sel ? oe4    : oe2;

   // Reference model: word-addressed memory image plus last load result.
   logic [15:0] ref2 [int];
   logic [15:0] ref4 [int];
   logic [31:0] last_rd [2];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [15:0] init_val(int a);
      return 16'(a) ^ 16'hA5A5;
   endfunction

   function automatic int haddr(logic [31:0] ad);
      logic [31:0] t;
      t = ad - 32'(BASE);
      return int'((t / 4) % 131072) * 2;
   endfunction

   function automatic logic [15:0] ref_rd(bit s, int a);
      if (s) return ref4.exists(a) ? ref4[a] : init_val(a);
      return ref2.exists(a) ? ref2[a] : init_val(a);
   endfunction

   task automatic ref_wr(bit s, int a, logic [15:0] d);
      if (s) ref4[a] = d;
      else   ref2[a] = d;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one instruction, count freeze cycles, return sampled at the DONE (or idle) cycle.
   task automatic do_op(input bit s, input bit r, input bit w, input logic [31:0] ad,
                        input logic [31:0] v, input int exp_stall, input bit drop);
      int wc, stall, we_lo, oe_lo, lo;
      wc = s ? 4 : 2;
      stall = 0; we_lo = 0; oe_lo = 0;
      lo = haddr(ad);
      sel = s; r_en = r; w_en = w; alu = ad; st = v;
      @(negedge clk);
      while (!rdy && stall < 40) begin
         if (stall == 1)      chk("addr_lo", 32'(sram_a), 32'(lo));
         if (stall == wc + 1) chk("addr_hi", 32'(sram_a), 32'(lo + 1));
         if (!we) we_lo++;
         if (!oe) oe_lo++;
         if (drop && stall == 2) begin r_en = 1'b0; w_en = 1'b0; end
         stall++;
         @(negedge clk);
      end
      chk("stall", 32'(stall), 32'(exp_stall));
      if (w) begin
         ref_wr(s, lo, v[15:0]);
         ref_wr(s, lo + 1, v[31:16]);
      end else if (r) begin
         last_rd[s] = {ref_rd(s, lo + 1), ref_rd(s, lo)};
      end
      chk("rdata", rdata, last_rd[s]);
      if (r | w) begin
         chk("we_low_cycles", 32'(we_lo), w ? 32'(2 * (wc - 1)) : 32'd0);
         chk("oe_low_cycles", 32'(oe_lo), w ? 32'd0 : 32'(2 * wc));
      end
   endtask

   typedef struct {
      bit          s;
      bit          r;
      bit          w;
      logic [31:0] ad;
      logic [31:0] v;
      int          stall;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl [10];

   initial begin
      sel = 1'b0; r_en = 1'b0; w_en = 1'b0; alu = '0; st = '0;
      last_rd[0] = '0; last_rd[1] = '0;
      for (int i = 0; i < 262144; i++) begin
         mem2[i] = init_val(i);
         mem4[i] = init_val(i);
      end

      tbl[0] = '{1'b0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 5, 32'h0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 5, 32'h0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 32'd1028, 32'h0,        5, 32'hDEADBEEF};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 5, 32'hDEADBEEF};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,        5, 32'h12345678};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 32'd1035, 32'h0,        5, 32'hCAFEF00D};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 32'd1024, 32'h0,        0, 32'hCAFEF00D};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 32'd1020, 32'hA1B2C3D4, 9, 32'h0};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 32'd1020, 32'h0,        9, 32'hA1B2C3D4};
      tbl[9] = '{1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,        9, 32'hA5A4A5A5};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(rdy2 & rdy4), 32'd1);
      chk("rst_rdata", rdata2 | rdata4, 32'h0);
      chk("rst_addr", 32'(a2 | a4), 32'h0);
      chk("rst_we_oe", {30'h0, we2 & we4, oe2 & oe4}, 32'h3);
      @(posedge clk); #1 rst = 1'b0;

      // Table: consecutive rows are back-to-back instructions
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].ad, tbl[i].v, tbl[i].stall, 1'b0);
         chk("tbl_rdata", rdata, tbl[i].rd);
         if (i == 0) chk("sram_0_1", {mem2[1], mem2[0]}, 32'h12345678);
         if (i == 7) chk("sram_wrap", {mem4[262143], mem4[262142]}, 32'hA1B2C3D4);
         @(posedge clk); #1;
      end

      // Request held through DONE must not start a second access
      do_op(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 5, 1'b0);
      @(posedge clk); #1 r_en = 1'b0;
      @(negedge clk); chk("no_reaccept_rdy", 32'(rdy), 32'd1);
      @(negedge clk); chk("no_reaccept_oe", {31'h0, oe}, 32'd1);
      chk("no_reaccept_rdy2", 32'(rdy), 32'd1);

      // Request dropped mid-access still completes on latched values
      @(posedge clk); #1;
      do_op(1'b0, 1'b0, 1'b1, 32'd1048, 32'h0BADF00D, 5, 1'b1);
      @(posedge clk); #1;
      do_op(1'b0, 1'b1, 1'b0, 32'd1048, 32'h0, 5, 1'b0);
      chk("drop_load", rdata, 32'h0BADF00D);

      // Reset in the middle of a store: low half already written, high half not
      @(posedge clk); #1;
      sel = 1'b0; w_en = 1'b1; r_en = 1'b0; alu = 32'd1088; st = 32'h5555AAAA;
      repeat (3) @(negedge clk);
      rst = 1'b1; w_en = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(rdy2), 32'd1);
      chk("mid_rst_we", {31'h0, we2}, 32'd1);
      chk("mid_rst_oe", {31'h0, oe2}, 32'd1);
      chk("mid_rst_rdata", rdata2 | rdata4, 32'h0);
      chk("mid_rst_addr", 32'(a2), 32'h0);
      ref_wr(1'b0, haddr(32'd1088), 16'hAAAA);
      last_rd[0] = '0; last_rd[1] = '0;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      do_op(1'b0, 1'b1, 1'b0, 32'd1088, 32'h0, 5, 1'b0);

      // Randomized instruction stream against the model
      for (int i = 0; i < 60; i++) begin
         bit s, r, w, drop;
         int kind, wc;
         logic [31:0] ad;
         s    = 1'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 3));
         r    = (kind == 1) || (kind == 3);
         w    = (kind >= 2);
         if ($urandom_range(0, 7) == 0) ad = 32'(BASE) - 32'(4 * $urandom_range(1, 4));
         else ad = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         drop = ($urandom_range(0, 4) == 0);
         wc   = s ? 4 : 2;
         @(posedge clk); #1;
         do_op(s, r, w, ad, $urandom, (r | w) ? 2 * wc + 1 : 0, drop);
      end

      @(posedge clk); #1 r_en = 1'b0; w_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
